// File: rtl/gev_pkg.sv
// Shared types for the gated event scheduler: edge-mode encoding, dispatched event
// record and the edge-selection helper used by every channel.
package gev_pkg;

  localparam int GEV_NCH   = 4;
  localparam int GEV_CNT_W = 8;
  localparam int GEV_CH_W  = $clog2(GEV_NCH);

  typedef enum logic [1:0] {
    GEV_OFF = 2'b00,
    GEV_POS = 2'b01,
    GEV_NEG = 2'b10,
    GEV_ANY = 2'b11
  } gev_mode_e;

  typedef struct packed {
    logic [GEV_CH_W-1:0]  ch;
    logic [GEV_CNT_W-1:0] stamp;
  } gev_evt_t;

  function automatic logic gev_edge(gev_mode_e m, logic q, logic d);
    case (m)
      GEV_POS: return ~q & d;
      GEV_NEG: return q & ~d;
      GEV_ANY: return q ^ d;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gated_event_sched_if.sv
// Valid/ready event port between the scheduler (master) and its single consumer (slave).
interface gated_event_sched_if;
  import gev_pkg::*;

  logic     evt_valid;
  logic     evt_ready;
  gev_evt_t evt;

  modport master (output evt_valid, output evt, input  evt_ready);
  modport slave  (input  evt_valid, input  evt, output evt_ready);

endinterface

// File: rtl/gev_rr_arb.sv
// Round-robin arbiter: the first requester at or after ptr (wrapping) wins.
module gev_rr_arb #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/gated_event_sched.sv
// Qualified edge detection per channel, one pending slot each, round-robin dispatch
// through a single registered output stage carrying the capture timestamp.
module gated_event_sched
  import gev_pkg::*;
#(
  parameter int NCH   = GEV_NCH,
  parameter int CNT_W = GEV_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2*NCH-1:0]    cfg_mode_i,
  input  logic [NCH-1:0]      sig_i,
  input  logic [NCH-1:0]      en_i,
  input  logic                clr_ovf_i,
  gated_event_sched_if.master evt_if,
  output logic [NCH-1:0]      pend_o,
  output logic [NCH-1:0]      ovf_o
);

  localparam int CH_W = $clog2(NCH);

  logic [CNT_W-1:0] cnt;
  logic [NCH-1:0]   sig_q;
  logic             prime;
  logic [NCH-1:0]   pend, ovf, hit, req, gnt, take;
  logic [CNT_W-1:0] stamp [NCH];
  logic [CH_W-1:0]  rr, gidx;
  logic             gany, load;
  logic [CNT_W-1:0] sel_stamp;
  logic             out_valid;
  gev_evt_t         out_evt;

  always_comb begin
    hit = '0;
    for (int c = 0; c < NCH; c++)
      hit[c] = prime & en_i[c] &
               gev_edge(gev_mode_e'(cfg_mode_i[2*c +: 2]), sig_q[c], sig_i[c]);
  end

  // Live events compete alongside pending ones so an idle path dispatches next cycle.
  assign req = pend | hit;

  gev_rr_arb #(.N(NCH)) u_arb (
    .req (req),
    .ptr (rr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign load      = ~out_valid | evt_if.evt_ready;
  assign take      = load ? gnt : '0;
  assign sel_stamp = pend[gidx] ? stamp[gidx] : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      sig_q <= '0;
      prime <= 1'b0;
    end else begin
      cnt   <= cnt + CNT_W'(1);
      sig_q <= sig_i;
      prime <= 1'b1;
    end
  end

  // A granted channel hit in the same cycle keeps a pending slot with the new stamp;
  // an ungranted hit on a busy slot is lost and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      ovf  <= '0;
      for (int c = 0; c < NCH; c++) stamp[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (cfg_mode_i[2*c +: 2] == GEV_OFF) begin
          pend[c] <= 1'b0;
          ovf[c]  <= 1'b0;
        end else begin
          pend[c] <= (hit[c] & pend[c]) | (~take[c] & (hit[c] | pend[c]));
          if (hit[c] & (~pend[c] | take[c])) stamp[c] <= cnt;
          if (hit[c] & pend[c] & ~take[c]) ovf[c] <= 1'b1;
          else if (clr_ovf_i)              ovf[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_evt   <= '0;
      rr        <= '0;
    end else if (load) begin
      out_valid <= gany;
      if (gany) begin
        out_evt.ch    <= gidx;
        out_evt.stamp <= sel_stamp;
        rr            <= (gidx == CH_W'(NCH-1)) ? '0 : gidx + CH_W'(1);
      end
    end
  end

  assign evt_if.evt_valid = out_valid;
  assign evt_if.evt       = out_evt;
  assign pend_o           = pend;
  assign ovf_o            = ovf;

endmodule

// File: tb/tb_gated_event_sched.sv
// Directed bench for gated_event_sched: each task drives one scenario and checks
// {valid, ch, stamp, pend, ovf} against hand-derived values.
module tb_gated_event_sched;
  import gev_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cfg;
  logic [3:0] sig, en;
  logic       clr;
  logic [3:0] pend, ovf;
  logic [7:0] ncyc;
  logic [18:0] obs;
  int vectors = 0;
  int errors  = 0;

  gated_event_sched_if bus ();

  gated_event_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_mode_i (cfg),
    .sig_i      (sig),
    .en_i       (en),
    .clr_ovf_i  (clr),
    .evt_if     (bus),
    .pend_o     (pend),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;

  // Reference timestamp: cycles elapsed since reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ncyc <= 8'd0;
    else        ncyc <= ncyc + 8'd1;

  assign obs = {bus.evt_valid, bus.evt.ch, bus.evt.stamp, pend, ovf};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] s, input logic [7:0] c, input logic [3:0] e);
    rst_n = 1'b0;
    sig = s; cfg = c; en = e; clr = 1'b0; bus.evt_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sig = 4'h0; cfg = 8'h00; en = 4'h0; clr = 1'b0; bus.evt_ready = 1'b0;
    tick;
    vectors++;
    if (obs !== 19'h0) begin errors++; $display("FAIL reset_state: got %h want %h", obs, 19'h0); end
    rst_n = 1'b1;
    tick; tick;
    vectors++;
    if (obs !== 19'h0) begin errors++; $display("FAIL post_reset_idle: got %h want %h", obs, 19'h0); end
  endtask

  task automatic test_pos_gated;
    logic [7:0] e;
    do_reset(4'h0, 8'h01, 4'h0);
    bus.evt_ready = 1'b1;
    sig = 4'b0001; en = 4'b0000;
    tick;
    vectors++;
    if (obs !== 19'h0) begin errors++; $display("FAIL pos_en_low: got %h want %h", obs, 19'h0); end
    sig = 4'b0000;
    tick;
    sig = 4'b0001; en = 4'b0001; e = ncyc;
    tick;
    en = 4'b0000;
    vectors++;
    if (obs !== {1'b1, 2'd0, e, 4'b0000, 4'b0000}) begin
      errors++; $display("FAIL pos_en_high: got %h want %h", obs, {1'b1, 2'd0, e, 8'h00});
    end
    tick;
    vectors++;
    if (obs !== {1'b0, 2'd0, e, 4'b0000, 4'b0000}) begin
      errors++; $display("FAIL pos_drain: got %h want %h", obs, {1'b0, 2'd0, e, 8'h00});
    end
  endtask

  task automatic test_neg;
    logic [7:0] e;
    do_reset(4'b0010, 8'h08, 4'b0010);
    bus.evt_ready = 1'b1;
    sig = 4'b0000; e = ncyc;
    tick;
    vectors++;
    if (obs !== {1'b1, 2'd1, e, 4'b0000, 4'b0000}) begin
      errors++; $display("FAIL neg_dispatch: got %h want %h", obs, {1'b1, 2'd1, e, 8'h00});
    end
    tick;
    vectors++;
    if (obs !== {1'b0, 2'd1, e, 4'b0000, 4'b0000}) begin
      errors++; $display("FAIL neg_drain: got %h want %h", obs, {1'b0, 2'd1, e, 8'h00});
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    logic [3:0] exp_pend [4];
    exp_pend[0] = 4'b1110; exp_pend[1] = 4'b1100; exp_pend[2] = 4'b1000; exp_pend[3] = 4'b0000;
    do_reset(4'h0, 8'hFF, 4'hF);
    bus.evt_ready = 1'b1;
    sig = 4'hF; e = ncyc;
    tick;
    en = 4'h0;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs !== {1'b1, 2'(k), e, exp_pend[k], 4'b0000}) begin
        errors++; $display("FAIL b2b_ch%0d: got %h want %h", k, obs, {1'b1, 2'(k), e, exp_pend[k], 4'b0000});
      end
      tick;
    end
    vectors++;
    if (obs !== {1'b0, 2'd3, e, 4'b0000, 4'b0000}) begin
      errors++; $display("FAIL b2b_empty: got %h want %h", obs, {1'b0, 2'd3, e, 8'h00});
    end
  endtask

  task automatic test_overflow;
    logic [7:0] e0, e1;
    do_reset(4'h0, 8'h11, 4'b0101);
    sig = 4'b0001; e0 = ncyc;
    tick;
    sig = 4'b0101; e1 = ncyc;
    tick;
    vectors++;
    if (obs !== {1'b1, 2'd0, e0, 4'b0100, 4'b0000}) begin
      errors++; $display("FAIL ovf_first_pend: got %h want %h", obs, {1'b1, 2'd0, e0, 8'h40});
    end
    sig = 4'b0001; tick;
    sig = 4'b0101; tick;
    vectors++;
    if (obs !== {1'b1, 2'd0, e0, 4'b0100, 4'b0100}) begin
      errors++; $display("FAIL ovf_set: got %h want %h", obs, {1'b1, 2'd0, e0, 8'h44});
    end
    clr = 1'b1; tick; clr = 1'b0;
    vectors++;
    if (ovf !== 4'b0000) begin errors++; $display("FAIL ovf_clear: got %b want %b", ovf, 4'b0000); end
    sig = 4'b0001; tick;
    sig = 4'b0101; clr = 1'b1; tick; clr = 1'b0;
    vectors++;
    if (ovf !== 4'b0100) begin errors++; $display("FAIL ovf_set_wins: got %b want %b", ovf, 4'b0100); end
    clr = 1'b1; tick; clr = 1'b0;
    bus.evt_ready = 1'b1;
    tick;
    vectors++;
    if (obs !== {1'b1, 2'd2, e1, 4'b0000, 4'b0000}) begin
      errors++; $display("FAIL ovf_first_stamp: got %h want %h", obs, {1'b1, 2'd2, e1, 8'h00});
    end
    tick;
    vectors++;
    if (obs !== {1'b0, 2'd2, e1, 4'b0000, 4'b0000}) begin
      errors++; $display("FAIL ovf_drain: got %h want %h", obs, {1'b0, 2'd2, e1, 8'h00});
    end
  endtask

  task automatic test_stall;
    logic [7:0] e;
    do_reset(4'h0, 8'h40, 4'b1000);
    sig = 4'b1000; e = ncyc;
    tick;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (obs !== {1'b1, 2'd3, e, 4'b0000, 4'b0000}) begin
        errors++; $display("FAIL stall_hold%0d: got %h want %h", k, obs, {1'b1, 2'd3, e, 8'h00});
      end
      tick;
    end
    bus.evt_ready = 1'b1;
    tick;
    vectors++;
    if (obs !== {1'b0, 2'd3, e, 4'b0000, 4'b0000}) begin
      errors++; $display("FAIL stall_release: got %h want %h", obs, {1'b0, 2'd3, e, 8'h00});
    end
  endtask

  task automatic test_reset_midop;
    logic [7:0] e;
    do_reset(4'hF, 8'h55, 4'hF);
    bus.evt_ready = 1'b1;
    tick;
    vectors++;
    if (obs !== 19'h0) begin errors++; $display("FAIL prime_no_event: got %h want %h", obs, 19'h0); end
    bus.evt_ready = 1'b0;
    sig = 4'h0; tick;
    sig = 4'hF; e = ncyc; tick;
    vectors++;
    if (obs !== {1'b1, 2'd0, e, 4'b1110, 4'b0000}) begin
      errors++; $display("FAIL midop_loaded: got %h want %h", obs, {1'b1, 2'd0, e, 8'he0});
    end
    rst_n = 1'b0;
    tick;
    vectors++;
    if (obs !== 19'h0) begin errors++; $display("FAIL midop_reset: got %h want %h", obs, 19'h0); end
    rst_n = 1'b1;
    tick; tick;
    vectors++;
    if (obs !== 19'h0) begin errors++; $display("FAIL midop_reprime: got %h want %h", obs, 19'h0); end
  endtask

  initial begin
    test_reset;
    test_pos_gated;
    test_neg;
    test_back_to_back;
    test_overflow;
    test_stall;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
